// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared exception codes, fetch state encoding and bubble PC
// for the IF stage.
package inst_fetch_pkg;
  localparam int EXC_CAUSE_W = 7;
  // Cause value meaning "no exception in this slot".
  localparam logic [EXC_CAUSE_W-1:0] EXC_NOP  = 7'h7f;
  localparam logic [EXC_CAUSE_W-1:0] EXC_ADEF = 7'h08;

  localparam logic [31:0] IF_BUBBLE_PC = 32'h00000100;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ADDR,
    WAIT_DATA,
    HOLD,
    CANCEL
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch_fsm.sv
// inst_fetch_fsm: fetch handshake sequencing; tracks a pending cancel so the
// response of a flushed request is dropped exactly once.
module inst_fetch_fsm
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         accept_i,
  input  logic         misaligned_i,
  input  logic         addr_ok_i,
  input  logic         data_ok_i,
  output fetch_state_e state_o,
  output logic         issue_o,
  output logic         capture_o,
  output logic         adef_o
);
  fetch_state_e state_q, state_d;
  logic         cancel_q, cancel_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cancel_d  = cancel_q;
    issue_o   = 1'b0;
    capture_o = 1'b0;
    adef_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (misaligned_i) begin
            adef_o  = 1'b1;
            state_d = HOLD;
          end else begin
            issue_o = 1'b1;
            state_d = WAIT_ADDR;
          end
        end
      end
      // The request cannot be withdrawn, so a flush here only marks it stale.
      WAIT_ADDR: begin
        if (addr_ok_i) begin
          state_d  = (cancel_q || flush_i) ? CANCEL : WAIT_DATA;
          cancel_d = 1'b0;
        end else if (flush_i) begin
          cancel_d = 1'b1;
        end
      end
      WAIT_DATA: begin
        if (flush_i) begin
          state_d = data_ok_i ? IDLE : CANCEL;
        end else if (data_ok_i) begin
          capture_o = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (flush_i || accept_i) state_d = IDLE;
      end
      CANCEL: begin
        if (data_ok_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: IF stage PC generation and single-outstanding instruction fetch.
// Define INST_FETCH_PERF_EN to add fetch/stall performance counters.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h1c000000,
  parameter logic [31:0] BUBBLE_PC = IF_BUBBLE_PC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [5:0]                  pause,
  input  logic                        branch_flush,
  input  logic [31:0]                 branch_target_addr,
  input  logic                        exception_flush,
  input  logic [31:0]                 exception_new_pc,
  output logic                        inst_req,
  output logic [31:0]                 inst_addr,
  input  logic                        inst_addr_ok,
  input  logic                        inst_data_ok,
  input  logic [31:0]                 inst_rdata,
  output logic [31:0]                 if_pc,
  output logic [31:0]                 if_inst,
  output logic [4:0]                  if_is_exception,
  output logic [4:0][EXC_CAUSE_W-1:0] if_exception_cause,
  output logic                        if_stallreq
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [31:0]                 perf_fetch_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);
  fetch_state_e state;
  logic         issue, capture, adef, flush, accept;
  logic [31:0]  pc_q, pc_d, addr_q, inst_q, flush_pc;
  logic         exc_q;
  logic         unused_pause;

  // Only the IF/ID stall bit matters; the PC stage is held via HOLD.
  assign unused_pause = ^{pause[5:2], pause[0]};

  assign flush    = exception_flush | (branch_flush & ~pause[1]);
  assign flush_pc = exception_flush ? exception_new_pc : branch_target_addr;
  assign accept   = (state == HOLD) & ~pause[1];

  inst_fetch_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .accept_i     (accept),
    .misaligned_i (|pc_q[1:0]),
    .addr_ok_i    (inst_addr_ok),
    .data_ok_i    (inst_data_ok),
    .state_o      (state),
    .issue_o      (issue),
    .capture_o    (capture),
    .adef_o       (adef)
  );

  always_comb begin
    pc_d = pc_q;
    if (flush)       pc_d = flush_pc;
    else if (accept) pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      addr_q <= RESET_PC;
      inst_q <= '0;
      exc_q  <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (issue) addr_q <= pc_q;
      if (flush) begin
        inst_q <= '0;
        exc_q  <= 1'b0;
      end else if (capture) begin
        inst_q <= inst_rdata;
        exc_q  <= 1'b0;
      end else if (adef) begin
        inst_q <= '0;
        exc_q  <= 1'b1;
      end
    end
  end

  assign inst_req    = (state == WAIT_ADDR);
  assign inst_addr   = addr_q;
  assign if_stallreq = (state != HOLD);

  always_comb begin
    if_pc              = BUBBLE_PC;
    if_inst            = '0;
    if_is_exception    = '0;
    if_exception_cause = {5{EXC_NOP}};
    if (state == HOLD) begin
      if_pc                 = pc_q;
      if_inst               = inst_q;
      if_is_exception[0]    = exc_q;
      if_exception_cause[0] = exc_q ? EXC_ADEF : EXC_NOP;
    end
  end

`ifdef INST_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept)      perf_fetch_q <= perf_fetch_q + 32'd1;
      if (if_stallreq) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a behavioural
// instruction memory of configurable addr_ok / data_ok latency.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c000000;
  localparam logic [31:0] BUB_PC = 32'h00000100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } out_t;

  logic                        clk, rst;
  logic [5:0]                  pause;
  logic                        branch_flush, exception_flush;
  logic [31:0]                 branch_target_addr, exception_new_pc;
  logic                        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0]                 inst_addr, inst_rdata;
  logic [31:0]                 if_pc, if_inst;
  logic [4:0]                  if_is_exception;
  logic [4:0][EXC_CAUSE_W-1:0] if_exception_cause;
  logic                        if_stallreq;

  int          n_vec = 0;
  int          n_err = 0;
  int          mem_alat = 0;
  int          mem_dlat = 2;
  logic [31:0] exp_req_q[$];
  out_t        exp_out_q[$];

  inst_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .pause              (pause),
    .branch_flush       (branch_flush),
    .branch_target_addr (branch_target_addr),
    .exception_flush    (exception_flush),
    .exception_new_pc   (exception_new_pc),
    .inst_req           (inst_req),
    .inst_addr          (inst_addr),
    .inst_addr_ok       (inst_addr_ok),
    .inst_data_ok       (inst_data_ok),
    .inst_rdata         (inst_rdata),
    .if_pc              (if_pc),
    .if_inst            (if_inst),
    .if_is_exception    (if_is_exception),
    .if_exception_cause (if_exception_cause),
    .if_stallreq        (if_stallreq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5a5aa5a5;
  endfunction

  task automatic push_req(input logic [31:0] a);
    exp_req_q.push_back(a);
  endtask

  task automatic push_out(input logic [31:0] a);
    out_t e;
    e.pc = a;
    e.inst = word(a);
    exp_out_q.push_back(e);
  endtask

  // Memory: one request at a time, addr_ok after mem_alat waiting cycles,
  // data_ok mem_dlat cycles after addr_ok.
  initial begin
    int aw, dc;
    logic [31:0] pa;
    aw = 0; dc = 0; pa = '0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    forever begin
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      if (rst) begin
        aw = 0; dc = 0;
      end else if (dc > 0) begin
        dc--;
        if (dc == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata = word(pa);
        end
      end else if (inst_req) begin
        if (aw >= mem_alat) begin
          inst_addr_ok = 1'b1;
          pa = inst_addr;
          dc = mem_dlat;
          aw = 0;
        end else begin
          aw++;
        end
      end
    end
  end

  // Monitor: samples mid-cycle, after all inputs for the next edge are set.
  initial begin
    bit prev_wait;
    logic [31:0] prev_addr, ea;
    out_t eo;
    prev_wait = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk); #2;
      if (if_stallreq === 1'b1) begin
        n_vec++;
        if (if_pc !== BUB_PC || if_inst !== 32'h0 || if_is_exception !== 5'h0) begin
          n_err++;
          $display("FAIL bubble: got pc=%h inst=%h exc=%b want pc=%h inst=0 exc=0",
                   if_pc, if_inst, if_is_exception, BUB_PC);
        end
      end
      if (!rst && prev_wait) begin
        n_vec++;
        if (inst_req !== 1'b1 || inst_addr !== prev_addr) begin
          n_err++;
          $display("FAIL req_stable: got req=%b addr=%h want req=1 addr=%h",
                   inst_req, inst_addr, prev_addr);
        end
      end
      prev_wait = !rst && inst_req && !inst_addr_ok;
      prev_addr = inst_addr;
      if (!rst && inst_req && inst_addr_ok) begin
        n_vec++;
        if (exp_req_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_req: got addr=%h want no request", inst_addr);
        end else begin
          ea = exp_req_q.pop_front();
          if (inst_addr !== ea) begin
            n_err++;
            $display("FAIL req_addr: got %h want %h", inst_addr, ea);
          end
        end
      end
      if (!rst && !if_stallreq && !pause[1] && !branch_flush && !exception_flush) begin
        n_vec++;
        if (exp_out_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_accept: got pc=%h inst=%h want none", if_pc, if_inst);
        end else begin
          eo = exp_out_q.pop_front();
          if (if_pc !== eo.pc || if_inst !== eo.inst) begin
            n_err++;
            $display("FAIL accept: got pc=%h inst=%h want pc=%h inst=%h",
                     if_pc, if_inst, eo.pc, eo.inst);
          end
        end
      end
    end
  end

  // Let the expected outputs drain, then freeze IF/ID and wait for the next HOLD.
  task automatic park(output bit ok);
    int n;
    n = 0;
    while (exp_out_q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    pause = 6'b000010;
    while (if_stallreq !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    ok = (n < 300);
  endtask

  task automatic test_reset();
    bit ok;
    logic [4:0][EXC_CAUSE_W-1:0] nop_cause;
    nop_cause = {5{EXC_NOP}};
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", inst_req); end
    n_vec++; if (inst_addr !== RST_PC) begin n_err++; $display("FAIL rst_addr: got %h want %h", inst_addr, RST_PC); end
    n_vec++; if (if_pc !== BUB_PC) begin n_err++; $display("FAIL rst_pc: got %h want %h", if_pc, BUB_PC); end
    n_vec++; if (if_inst !== 32'h0) begin n_err++; $display("FAIL rst_inst: got %h want 0", if_inst); end
    n_vec++; if (if_is_exception !== 5'h0) begin n_err++; $display("FAIL rst_exc: got %b want 0", if_is_exception); end
    n_vec++; if (if_exception_cause !== nop_cause) begin n_err++; $display("FAIL rst_cause: got %h want %h", if_exception_cause, nop_cause); end
    n_vec++; if (if_stallreq !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b want 1", if_stallreq); end
    for (int i = 0; i < 4; i++) push_req(RST_PC + 32'(4 * i));
    for (int i = 0; i < 3; i++) push_out(RST_PC + 32'(4 * i));
    #2 rst = 1'b0;
    park(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL fetch_seq_timeout: got timeout want HOLD"); end
    n_vec++; if (exp_req_q.size() != 0) begin n_err++; $display("FAIL fetch_seq_reqs: got %0d left want 0", exp_req_q.size()); end
    n_vec++; if (if_pc !== 32'h1c00000c) begin n_err++; $display("FAIL fetch_seq_pc: got %h want 1c00000c", if_pc); end
  endtask

  task automatic test_pause();
    bit ok;
    repeat (3) begin
      @(negedge clk); #1;
      n_vec++;
      if (if_pc !== 32'h1c00000c || if_inst !== word(32'h1c00000c) || inst_req !== 1'b0 || if_stallreq !== 1'b0) begin
        n_err++;
        $display("FAIL pause_hold: got pc=%h inst=%h req=%b stall=%b want pc=1c00000c inst=%h req=0 stall=0",
                 if_pc, if_inst, inst_req, if_stallreq, word(32'h1c00000c));
      end
    end
    push_out(32'h1c00000c); push_req(32'h1c000010);
    pause = 6'b000000;
    park(ok);
    n_vec++; if (!ok || exp_req_q.size() != 0) begin n_err++; $display("FAIL pause_resume: got ok=%b left=%0d want ok=1 left=0", ok, exp_req_q.size()); end
    n_vec++; if (if_pc !== 32'h1c000010) begin n_err++; $display("FAIL pause_pc: got %h want 1c000010", if_pc); end
  endtask

  // Redirect while the previous fetch is in WAIT_DATA; with data_lat=1 the
  // flush coincides with data_ok.
  task automatic flush_in_wait_data(input logic [31:0] held, input logic [31:0] tgt, input int dlat);
    bit ok;
    int n;
    mem_dlat = dlat;
    push_out(held); push_req(held + 32'd4);
    pause = 6'b000000;
    n = 0;
    while (exp_req_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    branch_target_addr = tgt;
    branch_flush = 1'b1;
    @(negedge clk);
    branch_flush = 1'b0;
    push_req(tgt); push_req(tgt + 32'd4); push_out(tgt);
    park(ok);
    mem_dlat = 2;
    n_vec++; if (n >= 100 || !ok || exp_req_q.size() != 0) begin n_err++; $display("FAIL br_wait_data: got n=%0d ok=%b left=%0d want done", n, ok, exp_req_q.size()); end
    n_vec++; if (if_pc !== tgt + 32'd4 || if_inst !== word(tgt + 32'd4)) begin n_err++; $display("FAIL br_wait_data_out: got pc=%h inst=%h want pc=%h", if_pc, if_inst, tgt + 32'd4); end
  endtask

  task automatic test_branch_flush();
    flush_in_wait_data(32'h1c000010, 32'h1c000100, 2);
  endtask

  task automatic test_flush_with_data();
    flush_in_wait_data(32'h1c000104, 32'h1c000300, 1);
  endtask

  task automatic test_wait_addr_flush();
    bit ok;
    int n;
    mem_alat = 2;
    push_out(32'h1c000304); push_req(32'h1c000308);
    pause = 6'b000000;
    n = 0;
    while (inst_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    branch_target_addr = 32'h1c000400;
    branch_flush = 1'b1;
    @(negedge clk);
    branch_flush = 1'b0;
    push_req(32'h1c000400); push_req(32'h1c000404); push_out(32'h1c000400);
    park(ok);
    mem_alat = 0;
    n_vec++; if (n >= 100 || !ok || exp_req_q.size() != 0) begin n_err++; $display("FAIL br_wait_addr: got n=%0d ok=%b left=%0d want done", n, ok, exp_req_q.size()); end
    n_vec++; if (if_pc !== 32'h1c000404) begin n_err++; $display("FAIL br_wait_addr_pc: got %h want 1c000404", if_pc); end
  endtask

  task automatic test_exc_priority();
    bit ok;
    push_req(32'h1c008000); push_req(32'h1c008004); push_out(32'h1c008000);
    exception_new_pc = 32'h1c008000; exception_flush = 1'b1;
    branch_target_addr = 32'h1c000200; branch_flush = 1'b1;
    pause = 6'b000000;
    @(negedge clk);
    exception_flush = 1'b0; branch_flush = 1'b0;
    park(ok);
    n_vec++; if (!ok || exp_req_q.size() != 0) begin n_err++; $display("FAIL exc_prio: got ok=%b left=%0d want ok=1 left=0", ok, exp_req_q.size()); end
    n_vec++; if (if_pc !== 32'h1c008004) begin n_err++; $display("FAIL exc_prio_pc: got %h want 1c008004", if_pc); end
  endtask

  task automatic test_adef();
    int n;
    logic [4:0][EXC_CAUSE_W-1:0] adef_cause;
    adef_cause = {5{EXC_NOP}};
    adef_cause[0] = EXC_ADEF;
    pause = 6'b000000;
    branch_target_addr = 32'h1c000102; branch_flush = 1'b1;
    @(negedge clk);
    branch_flush = 1'b0;
    pause = 6'b000010;
    n = 0;
    while (if_stallreq !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (n >= 50) begin n_err++; $display("FAIL adef_timeout: got timeout want HOLD"); end
    n_vec++; if (if_pc !== 32'h1c000102 || if_inst !== 32'h0) begin n_err++; $display("FAIL adef_out: got pc=%h inst=%h want pc=1c000102 inst=0", if_pc, if_inst); end
    n_vec++; if (if_is_exception !== 5'b00001) begin n_err++; $display("FAIL adef_exc: got %b want 00001", if_is_exception); end
    n_vec++; if (if_exception_cause !== adef_cause) begin n_err++; $display("FAIL adef_cause: got %h want %h", if_exception_cause, adef_cause); end
    n_vec++; if (inst_req !== 1'b0) begin n_err++; $display("FAIL adef_req: got %b want 0", inst_req); end
  endtask

  task automatic test_wrap();
    bit ok;
    push_req(32'hfffffffc); push_req(32'h00000000); push_out(32'hfffffffc);
    exception_new_pc = 32'hfffffffc; exception_flush = 1'b1;
    pause = 6'b000000;
    @(negedge clk);
    exception_flush = 1'b0;
    park(ok);
    n_vec++; if (!ok || exp_req_q.size() != 0) begin n_err++; $display("FAIL wrap: got ok=%b left=%0d want ok=1 left=0", ok, exp_req_q.size()); end
    n_vec++; if (if_pc !== 32'h0 || if_inst !== word(32'h0)) begin n_err++; $display("FAIL wrap_pc: got pc=%h inst=%h want pc=0 inst=%h", if_pc, if_inst, word(32'h0)); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    mem_alat = 5;
    push_out(32'h00000000);
    pause = 6'b000000;
    n = 0;
    while (inst_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    #3 rst = 1'b1;
    #1;
    n_vec++; if (n >= 50 || inst_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_req: got n=%0d req=%b want req=0", n, inst_req); end
    n_vec++; if (inst_addr !== RST_PC) begin n_err++; $display("FAIL rst_mid_addr: got %h want %h", inst_addr, RST_PC); end
    repeat (2) @(negedge clk);
    mem_alat = 0;
    push_req(RST_PC); push_req(RST_PC + 32'd4); push_out(RST_PC);
    #3 rst = 1'b0;
    park(ok);
    n_vec++; if (!ok || exp_req_q.size() != 0 || exp_out_q.size() != 0) begin n_err++; $display("FAIL rst_mid_refetch: got ok=%b left=%0d want ok=1 left=0", ok, exp_req_q.size()); end
    n_vec++; if (if_pc !== RST_PC + 32'd4) begin n_err++; $display("FAIL rst_mid_pc: got %h want %h", if_pc, RST_PC + 32'd4); end
  endtask

  initial begin
    rst = 1'b1;
    pause = 6'b000000;
    branch_flush = 1'b0; branch_target_addr = '0;
    exception_flush = 1'b0; exception_new_pc = '0;
    test_reset();
    test_pause();
    test_branch_flush();
    test_flush_with_data();
    test_wait_addr_flush();
    test_exc_priority();
    test_adef();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
